// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode/execute control unit for the SimpleComputer datapath.
// It owns the instruction register. It also drives the one-hot bus strobes for the
// program counter, the memory, and the accumulator/ALU.
// Memory accesses complete on MRDY. A watchdog faults the unit when MRDY stays low too long.
//
// Ports
//   CLK      system clock (rising edge)
//   AR       synchronous active-high reset
//   DATA_IN  DATA bus value (memory read data)
//   MRDY     memory ready, completes the current read/write this cycle
//   ZF, NF   accumulator zero / negative flags
//   PCC      PC increment
//   POA      PC drives ADDR
//   PLA      PC loads from ADDR
//   POD      PC drives DATA (reserved, held 0)
//   PLD      PC loads from DATA (reserved, held 0)
//   IRA      IR operand field drives ADDR
//   MRD      memory read onto DATA
//   MWR      memory write from DATA
//   ACL      accumulator load
//   ACO      accumulator drives DATA
//   ALU_SUB  ALU subtract select (valid with ALU_EN)
//   ALU_EN   accumulator loads the ALU result instead of DATA
//   IR       instruction register
//   HALTED   in HALT or FAULT
//   FAULT    memory watchdog expired
//
// Strobes are decoded combinationally from state, IR, MRDY and the flags.
// This lets ACL assert in the same cycle that memory completes.
module ctrl_sequencer #(
  parameter int unsigned DATAW    = 16,
  parameter int unsigned ADDRW    = 8,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             AR,
  input  logic [DATAW-1:0] DATA_IN,
  input  logic             MRDY,
  input  logic             ZF,
  input  logic             NF,
  output logic             PCC,
  output logic             POA,
  output logic             PLA,
  output logic             POD,
  output logic             PLD,
  output logic             IRA,
  output logic             MRD,
  output logic             MWR,
  output logic             ACL,
  output logic             ACO,
  output logic             ALU_SUB,
  output logic             ALU_EN,
  output logic [DATAW-1:0] IR,
  output logic             HALTED,
  output logic             FAULT
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 8;

  // Last count value before the watchdog fires on a further MRDY=0 cycle
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(WAIT_MAX - 1);

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_STA = 4'h2;
  localparam logic [OPW-1:0] OP_ADD = 4'h3;
  localparam logic [OPW-1:0] OP_SUB = 4'h4;
  localparam logic [OPW-1:0] OP_JMP = 4'h5;
  localparam logic [OPW-1:0] OP_JZ  = 4'h6;
  localparam logic [OPW-1:0] OP_JN  = 4'h7;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  // Elaboration guards: operand field must fit under the opcode, watchdog fits the counter
  if (ADDRW + OPW > DATAW) begin : g_bad_addrw
    $error("ctrl_sequencer: ADDRW too wide for DATAW");
  end
  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("ctrl_sequencer: WAIT_MAX must be 1..255");
  end

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EX_MEM = 3'd2,
    ST_EX_JMP = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATAW-1:0]  ir_q, ir_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]    opcode;

  assign opcode = ir_q[DATAW-1 -: OPW];
  assign IR     = ir_q;

  // State register, instruction register and watchdog counter
  always_ff @(posedge CLK) begin
    if (AR) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  // The counter defaults to 0, so it clears on MRDY, on any state change,
  // and outside the two memory-waiting states.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_FETCH: begin
        if (MRDY) begin
          ir_d    = DATA_IN;
          state_d = ST_DECODE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_DECODE: begin
        unique case (opcode)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_EX_MEM;
          OP_JMP:                         state_d = ST_EX_JMP;
          OP_JZ:                          state_d = ZF ? ST_EX_JMP : ST_FETCH;
          OP_JN:                          state_d = NF ? ST_EX_JMP : ST_FETCH;
          OP_HLT:                         state_d = ST_HALT;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_EX_MEM: begin
        if (MRDY) begin
          state_d = ST_FETCH;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_EX_JMP: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output decode; every strobe is suppressed while AR is high
  always_comb begin
    PCC     = 1'b0;
    POA     = 1'b0;
    PLA     = 1'b0;
    POD     = 1'b0;
    PLD     = 1'b0;
    IRA     = 1'b0;
    MRD     = 1'b0;
    MWR     = 1'b0;
    ACL     = 1'b0;
    ACO     = 1'b0;
    ALU_SUB = 1'b0;
    ALU_EN  = 1'b0;
    HALTED  = (state_q == ST_HALT) || (state_q == ST_FAULT);
    FAULT   = (state_q == ST_FAULT);
    if (!AR) begin
      unique case (state_q)
        ST_FETCH: begin
          POA = 1'b1;
          MRD = 1'b1;
        end
        ST_DECODE: PCC = 1'b1;
        ST_EX_MEM: begin
          IRA = 1'b1;
          unique case (opcode)
            OP_LDA: begin
              MRD = 1'b1;
              ACL = MRDY;
            end
            OP_STA: begin
              ACO = 1'b1;
              MWR = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              MRD     = 1'b1;
              ALU_EN  = 1'b1;
              ALU_SUB = (opcode == OP_SUB);
              ACL     = MRDY;
            end
            default: ;
          endcase
        end
        ST_EX_JMP: begin
          IRA = 1'b1;
          PLA = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Fetch/decode/execute control unit for the SimpleComputer datapath. It owns the instruction register and drives the one-hot bus strobes consumed by the program counter, memory, and accumulator/ALU. It produces the PCC/POA/PLA/POD/PLD controls that the PC stage samples each clock. Memory is variable-latency via an MRDY handshake, guarded by a wait watchdog.

Parameters:
DATAW, 16, data bus / instruction width
ADDRW, 8, address bus width; operand field is IR[ADDRW-1:0]
WAIT_MAX, 15, max cycles a memory access may wait for MRDY before FAULT (1..255)

Ports:
CLK  in  1  system clock, all state updates on rising edge
AR  in  1  reset, synchronous, active-high
DATA_IN  in  DATAW  value currently on DATA bus (memory read data)
MRDY  in  1  memory ready; completes current read/write in the cycle it is high
ZF  in  1  accumulator zero flag
NF  in  1  accumulator negative flag
PCC  out  1  PC increment
POA  out  1  PC drives ADDR
PLA  out  1  PC loads from ADDR
POD  out  1  PC drives DATA (reserved, held 0 in this ISA)
PLD  out  1  PC loads from DATA (reserved, held 0)
IRA  out  1  IR operand field drives ADDR
MRD  out  1  memory read onto DATA
MWR  out  1  memory write from DATA
ACL  out  1  accumulator loads (from DATA or ALU result)
ACO  out  1  accumulator drives DATA
ALU_SUB  out  1  ALU op select: 0 add, 1 subtract; valid when ALU_EN
ALU_EN  out  1  ACL takes ALU result instead of DATA
IR  out  DATAW  instruction register
HALTED  out  1  in HALT or FAULT state
FAULT  out  1  memory watchdog expired

Behaviour:
- Opcode = IR[15:12]: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 JN, F HLT; 8–E execute as NOP.
- States: FETCH, DECODE, EX_MEM, EX_JMP, HALT, FAULT. State register plus IR plus wait counter are the only storage. Outputs are decoded from state, IR, MRDY, and flags.
- While AR=1: next state FETCH, IR<=0, wait counter<=0. All strobes are forced 0 in any cycle AR=1, including mid-access. HALTED=0 and FAULT=0 after reset.
- FETCH: POA=1, MRD=1. If MRDY=1: IR<=DATA_IN, go to DECODE. Otherwise stay.
- DECODE: PCC=1 for exactly one cycle, unconditionally. Then:
  - NOP and 8–E go to FETCH.
  - LDA, STA, ADD, SUB go to EX_MEM.
  - JMP goes to EX_JMP.
  - JZ goes to EX_JMP if ZF=1, else FETCH.
  - JN goes to EX_JMP if NF=1, else FETCH.
  - HLT goes to HALT.
  - Flags are sampled in the DECODE cycle.
- EX_MEM: IRA=1 throughout.
  - LDA: MRD=1; ACL=1 only in the MRDY cycle.
  - STA: ACO=1, MWR=1.
  - ADD/SUB: MRD=1, ALU_EN=1, ALU_SUB=(op==SUB); ACL=1 only in the MRDY cycle.
  - On MRDY=1, go to FETCH.
- EX_JMP: IRA=1, PLA=1 for one cycle, then FETCH. PCC and PLA are never both 1.
- HALT: all strobes 0, HALTED=1. Held until AR.
- Watchdog: the counter clears on entry to FETCH/EX_MEM and whenever MRDY=1. It increments each waiting cycle (MRDY=0). When the counter reaches WAIT_MAX with MRDY still 0, go to FAULT.
- FAULT: strobes 0, HALTED=1, FAULT=1. Held until AR.
- Bus exclusivity invariants, every cycle:
  - At most one of {POA, IRA} drives ADDR.
  - At most one of {MRD, ACO, POD} drives DATA.
- Zero-wait latencies (MRDY always 1):
  - NOP, taken-not jumps, and HLT: 2 cycles.
  - JMP and taken JZ/JN: 3 cycles.
  - LDA/STA/ADD/SUB: 3 cycles.
- Wait states add 1 cycle per MRDY=0 cycle.

Test Plan:
- Reset, then MRDY=1 with DATA_IN=0x1042 (LDA 0x42): cycle 1 POA=MRD=1, IR=0x1042; cycle 2 PCC=1; cycle 3 IRA=MRD=ACL=1; back in FETCH on cycle 4.
- STA 0x20 (0x2020) with MRDY low 3 cycles in EX_MEM: IRA=ACO=MWR=1 held 4 cycles, no ACL, then FETCH. Check PCC is pulsed exactly once per instruction.
- JZ 0x80 (0x6080), two runs: ZF=1 at DECODE gives PLA=1, IRA=1 one cycle, PCC≠PLA same cycle. ZF=0 gives FETCH immediately after DECODE with no PLA.
- SUB 0x10 (0x4010): ALU_EN=1, ALU_SUB=1, ACL=1 in MRDY cycle. ADD (0x3010) gives ALU_SUB=0.
- HLT (0xF000): HALTED=1, all strobes 0 for 20 cycles. Assert AR one cycle: next cycle FETCH, IR=0, POA=1.
- Watchdog, WAIT_MAX=15, MRDY held 0 in FETCH: FAULT=1 and HALTED=1 after 15 wait cycles, strobes 0. AR asserted mid-wait on a second run clears without FAULT.
